beat_packer: RTL and testbench

Downstream consumer of the skid buffer. It packs RATIO consecutive DW-bit stream beats into one DW*RATIO-bit word, and closes a partial word early on `in_last`. The input-side ready is driven directly from a state-register bit, with no combinational path from `out_ready`. This lets the skid buffer upstream absorb the one-cycle stall latency.

---
 rtl/beat_packer_pkg.sv | 11 +
 rtl/beat_packer_if.sv | 27 ++
 rtl/beat_packer_lanes.sv | 43 ++++
 rtl/beat_packer.sv | 115 +++++++++++
 tb/tb_beat_packer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/beat_packer_pkg.sv
// rtl/beat_packer_pkg.sv - shared FSM encodings and counter sizing for the beat packer
package beat_packer_pkg;

  localparam logic [1:0] FILL = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/beat_packer_if.sv
// rtl/beat_packer_if.sv - narrow input stream and packed output stream of the beat packer
interface beat_packer_if #(
  parameter int DW    = 16,
  parameter int RATIO = 4
);

  logic [DW-1:0]       in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [DW*RATIO-1:0] out_data;
  logic [RATIO-1:0]    out_keep;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );

endinterface

// File: rtl/beat_packer_lanes.sv
// rtl/beat_packer_lanes.sv - assembly lanes, keep mask and lane counter
module packer_lanes
  import beat_packer_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RATIO = 4,
  parameter int CW    = cnt_width(RATIO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                clr,
  input  logic [DW-1:0]       wr_data,
  output logic [DW*RATIO-1:0] lane_data,
  output logic [RATIO-1:0]    keep,
  output logic [CW-1:0]       cnt,
  output logic                full_word
);

  assign full_word = (cnt == CW'(RATIO - 1));

  // Lane data is cleared with the keep mask so unwritten lanes read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_data <= '0;
      keep      <= '0;
      cnt       <= '0;
    end else if (clr) begin
      lane_data <= '0;
      keep      <= '0;
      cnt       <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt == CW'(i)) begin
          lane_data[i*DW +: DW] <= wr_data;
          keep[i]               <= 1'b1;
        end
      end
      cnt <= full_word ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs RATIO narrow beats into one wide word with registered in_ready
module beat_packer
  import beat_packer_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RATIO = 4
) (
  input  logic          clk,
  input  logic          rst,
  beat_packer_if.slave  bus
);

  localparam int CW = cnt_width(RATIO);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                accept;
  logic                complete;
  logic                free;
  logic                load_beat;
  logic                load_hold;
  logic                wr_en;
  logic                clr;
  logic                full_word;
  logic                hold_last;
  logic [CW-1:0]       cnt;
  logic [DW*RATIO-1:0] lane_data;
  logic [DW*RATIO-1:0] merged_data;
  logic [RATIO-1:0]    keep;
  logic [RATIO-1:0]    merged_keep;
  logic [DW*RATIO-1:0] out_data_q;
  logic [RATIO-1:0]    out_keep_q;
  logic                out_last_q;
  logic                out_valid_q;

  packer_lanes #(.DW(DW), .RATIO(RATIO), .CW(CW)) u_lanes (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .clr       (clr),
    .wr_data   (bus.in_data),
    .lane_data (lane_data),
    .keep      (keep),
    .cnt       (cnt),
    .full_word (full_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (complete && !free) state_nxt = HOLD;
      HOLD:    if (free) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // A completing beat bypasses the lanes straight into the output register when it is free.
  always_comb begin
    accept    = bus.in_valid & state[0];
    complete  = accept & (full_word | bus.in_last);
    free      = !out_valid_q | bus.out_ready;
    load_beat = complete & free;
    load_hold = state[1] & free;
    wr_en     = accept & !load_beat;
    clr       = load_beat | load_hold;
  end

  always_comb begin
    merged_data = lane_data;
    merged_keep = keep;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt == CW'(i)) begin
        merged_data[i*DW +: DW] = bus.in_data;
        merged_keep[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      hold_last   <= 1'b0;
    end else begin
      if (complete && !free) hold_last <= bus.in_last;
      if (load_beat) begin
        out_data_q  <= merged_data;
        out_keep_q  <= merged_keep;
        out_last_q  <= bus.in_last;
        out_valid_q <= 1'b1;
      end else if (load_hold) begin
        out_data_q  <= lane_data;
        out_keep_q  <= keep;
        out_last_q  <= hold_last;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = state[0];
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - scoreboard bench for beat_packer with DW=16, RATIO=4
module tb_beat_packer;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;
  logic [63:0] m_data;
  logic [3:0]  m_keep;
  int          m_cnt;
  int          cyc;

  beat_packer_if #(.DW(16), .RATIO(4)) bus ();

  beat_packer #(.DW(16), .RATIO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_data = '0;
    m_keep = '0;
    m_cnt  = 0;
  endtask

  task automatic model_accept(input logic [15:0] d, input logic l);
    exp_t x;
    m_data[m_cnt*16 +: 16] = d;
    m_keep[m_cnt]          = 1'b1;
    if (m_cnt == 3 || l) begin
      x.d = m_data;
      x.k = m_keep;
      x.l = l;
      q.push_back(x);
      model_clear();
    end else begin
      m_cnt++;
    end
  endtask

  // Inputs change 1ns after a rising edge; in_ready is registered so the falling-edge sample holds.
  task automatic send(input logic [15:0] d, input logic l, output int cycles);
    logic ok;
    cycles       = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end while (!ok && cycles < 200);
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    else     model_accept(d, l);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", 64'(bus.out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("word_data", bus.out_data, e.d);
        check("word_keep", 64'(bus.out_keep), 64'(e.k));
        check("word_last", 64'(bus.out_last), 64'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_keep", 64'(bus.out_keep), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h1111 * (i + 1)), 1'b0, cyc);
      check("stream_rate", 64'(cyc), 64'd1);
      if (i == 3) begin
        check("stream_valid", 64'(bus.out_valid), 64'd1);
        check("stream_data", bus.out_data, 64'h4444_3333_2222_1111);
        check("stream_keep", 64'(bus.out_keep), 64'hF);
      end
    end
    drain();

    send(16'hAAAA, 1'b0, cyc);
    send(16'hBBBB, 1'b1, cyc);
    check("partial_data", bus.out_data, 64'h0000_0000_BBBB_AAAA);
    check("partial_keep", 64'(bus.out_keep), 64'h3);
    check("partial_last", 64'(bus.out_last), 64'd1);
    drain();

    for (int i = 0; i < 4; i++) send(16'hD001 + 16'(i), (i == 3), cyc);
    check("last_full_keep", 64'(bus.out_keep), 64'hF);
    check("last_full_last", 64'(bus.out_last), 64'd1);
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0A01 + 16'(i), 1'b0, cyc);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_hold", 64'(bus.in_ready), 64'd0);
    check("bp_word1_held", bus.out_data, 64'h0A04_0A03_0A02_0A01);
    bus.out_ready = 1'b1;
    drain();
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'hB001 + 16'(i), 1'b0, cyc);
    for (int i = 0; i < 3; i++) send(16'hC001 + 16'(i), 1'b0, cyc);
    bus.out_ready = 1'b1;
    send(16'hC004, 1'b0, cyc);
    check("reload_valid", 64'(bus.out_valid), 64'd1);
    check("reload_data", bus.out_data, 64'hC004_C003_C002_C001);
    check("reload_fill", 64'(bus.in_ready), 64'd1);
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'hE001 + 16'(i), 1'b0, cyc);
    check("pre_rst_hold", 64'(bus.in_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_keep", 64'(bus.out_keep), 64'd0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'hC0DE, 1'b1, cyc);
    check("post_rst_data", bus.out_data, 64'h0000_0000_0000_C0DE);
    check("post_rst_keep", 64'(bus.out_keep), 64'h1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
